// File: rtl/ext_ram_ctrl.sv
// Extrinsic-RAM sequencer: one frame-length LOAD, CLEAR or DUMP per start; RAM port registered (+1 cycle), read data +2.
// LOAD stalls on in_valid, DUMP stalls on out_ready via a 4-entry FIFO whose space is reserved at read issue.
module ext_ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FRAME_LEN  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_we,
  output logic                  ram_cs,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CLEAR = 3'd2;
  localparam logic [2:0] S_DUMP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH:0] FLEN     = (ADDR_WIDTH+1)'(FRAME_LEN);

  logic [2:0]            state;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH:0]   pop_cnt;
  logic                  rd_pend1;
  logic                  rd_pend2;
  logic [1:0]            outstanding;
  logic [DATA_WIDTH-1:0] fifo_mem [4];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            fifo_count;
  logic                  load_beat;
  logic                  clr_wr;
  logic                  rd_issue;
  logic                  push;
  logic                  pop;

  assign busy      = (state == S_LOAD) || (state == S_CLEAR) || (state == S_DUMP);
  assign done      = (state == S_DONE);
  assign in_ready  = (state == S_LOAD);
  assign load_beat = in_ready && in_valid;
  assign clr_wr    = (state == S_CLEAR);

  // A read is only issued if the FIFO can hold it together with every read still in flight.
  assign outstanding = {1'b0, rd_pend1} + {1'b0, rd_pend2};
  assign rd_issue    = (state == S_DUMP) && (cnt < FLEN) &&
                       (({1'b0, fifo_count} + {2'b00, outstanding}) < 4'd4);
  assign push        = rd_pend2;
  assign out_valid   = (fifo_count != 3'd0);
  assign pop         = out_valid && out_ready;
  assign out_data    = out_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pop_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          pop_cnt <= '0;
          if (start) begin
            case (mode)
              2'b00:   state <= S_LOAD;
              2'b01:   state <= S_CLEAR;
              2'b10:   state <= S_DUMP;
              default: state <= S_IDLE;
            endcase
          end
        end
        S_LOAD: begin
          if (load_beat) begin
            cnt <= cnt + CNT_ONE;
            if (cnt == LAST_IDX) state <= S_DONE;
          end
        end
        S_CLEAR: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == LAST_IDX) state <= S_DONE;
        end
        S_DUMP: begin
          if (rd_issue) cnt <= cnt + CNT_ONE;
          if (pop) begin
            pop_cnt <= pop_cnt + CNT_ONE;
            if (pop_cnt == LAST_IDX) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      rd_pend1    <= 1'b0;
      rd_pend2    <= 1'b0;
    end else begin
      ram_cs   <= load_beat || clr_wr || rd_issue;
      ram_we   <= load_beat || clr_wr;
      rd_pend1 <= rd_issue;
      rd_pend2 <= rd_pend1;
      if (load_beat || clr_wr || rd_issue) ram_address <= cnt[ADDR_WIDTH-1:0];
      if (load_beat)   ram_data_in <= in_data;
      else if (clr_wr) ram_data_in <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= ram_data_out;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
